// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with optional post-frame idle gap.
// Define SER_PARITY_EN to append an even-parity bit after data[0].
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SER_PARITY_EN
    PAR   = 2'd2,
`endif
    WAIT  = 2'd3
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
`ifdef SER_PARITY_EN
  logic             par_bit;
`endif

  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            // MSB goes out immediately; the register holds the remaining bits
            sreg       <= data << 1;
            sout       <= data[WIDTH-1];
            sout_valid <= 1'b1;
            done       <= 1'b0;
            cnt        <= CW'(1);
`ifdef SER_PARITY_EN
            par_bit    <= ^data;
`endif
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST_BIT) begin
            cnt <= '0;
`ifdef SER_PARITY_EN
            sout       <= par_bit;
            sout_valid <= 1'b1;
            done       <= 1'b1;
            state      <= PAR;
`else
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
            gcnt       <= '0;
            state      <= (GAP > 0) ? WAIT : IDLE;
`endif
          end else begin
            sout <= sreg[WIDTH-1];
            sreg <= sreg << 1;
            cnt  <= cnt + CW'(1);
`ifdef SER_PARITY_EN
            done <= 1'b0;
`else
            done <= (cnt == LAST_BIT - CW'(1));
`endif
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
          gcnt       <= '0;
          state      <= (GAP > 0) ? WAIT : IDLE;
        end
`endif
        WAIT: begin
          if (gcnt == GAP_LAST) state <= IDLE;
          else gcnt <= gcnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, 8, data word width in bits; legal range 2..32.
REQ-002 Parameter GAP, 0, idle cycles inserted after each frame; legal range 0..15.
REQ-003 Port clk  input  1  single clock; all state changes SHALL occur on its rising edge.
REQ-004 Port clr  input  1  reset, asynchronous and active-low.
REQ-005 Port data  input  WIDTH  parallel word to transmit; sampled only when accepted.
REQ-006 Port load  input  1  load request; a word is accepted when load=1 and ready=1 at a rising clk.
REQ-007 Port ready  output  1  high when a new word can be accepted.
REQ-008 Port sout  output  1  serial bit stream for the downstream pattern detector's "in" input; SHALL be 0 whenever sout_valid=0.
REQ-009 Port sout_valid  output  1  high on every cycle that carries a frame bit.
REQ-010 Port done  output  1  one-cycle pulse, high during the last bit of each frame.

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT, PAR and WAIT; PAR exists only with SER_PARITY_EN.
REQ-012 IDLE: ready=1, sout_valid=0, sout=0; on accept, data SHALL be captured into the shift register and the FSM SHALL go to SHIFT.
REQ-013 If the word is accepted at edge k, cycles k+1..k+WIDTH SHALL carry data[WIDTH-1] down to data[0], MSB first, with sout_valid=1.
REQ-014 SHIFT SHALL use a bit counter of ceil(log2(WIDTH+1)) bits and SHALL leave SHIFT after exactly WIDTH cycles.
REQ-015 After SHIFT the FSM SHALL go to PAR if that state is enabled, else to WAIT if GAP>0, else to IDLE.
REQ-016 WAIT SHALL last exactly GAP cycles with ready=0, sout_valid=0, sout=0, then return to IDLE.
REQ-017 ready SHALL be 0 in SHIFT, PAR and WAIT; load in those states SHALL be ignored and not queued.
REQ-018 Changes on data after acceptance SHALL NOT affect the frame in progress.
REQ-019 done SHALL be high only in the final valid cycle of the frame: the parity bit if enabled, else data[0].
REQ-020 The minimum spacing between frames SHALL be one idle cycle (GAP=0), because ready is asserted only in IDLE.
REQ-021 All outputs SHALL be registered or decoded from the state register only, with no combinational path from load or data.

Reset
REQ-022 clr=0 SHALL immediately, without waiting for clk, force:
- state IDLE
- shift register and counter 0
- sout=0, sout_valid=0, done=0, ready=1
REQ-023 Reset asserted mid-frame SHALL abort the frame; no further bits of that word SHALL appear after clr is released.
REQ-024 The first accept SHALL be possible at the first rising clk after clr returns to 1.

Configuration
REQ-025 Macro SER_PARITY_EN defined: after data[0], one extra cycle (PAR) SHALL carry the even-parity bit (XOR of all WIDTH data bits) with sout_valid=1; frame length WIDTH+1.
REQ-026 Macro SER_PARITY_EN undefined: no PAR state and no parity logic; frame length WIDTH.

Verification
REQ-027 The bench SHALL cover the following scenarios (WIDTH=8):
- Basic frame: GAP=0, no parity, load 8'hA5 at edge k -> sout 1,0,1,0,0,1,0,1 on k+1..k+8; done at k+8; ready=1 at k+9.
- Parity: SER_PARITY_EN defined, load 8'h07 -> bits 0,0,0,0,0,1,1,1 then parity 1 at k+9; done at k+9. Load 8'hA5 -> parity 0.
- Gap: GAP=2, back-to-back loads of 8'hFF and 8'h01 held high -> frame 1 on k+1..k+8; idle k+9..k+10; second accept at k+11; 8'h01 bits on k+12..k+19.
- Load while busy: load 8'h3C, then load=1 with data=8'hFF at k+3 -> ignored; stream stays 0,0,1,1,1,1,0,0.
- Reset mid-frame: clr=0 asynchronously between edges k+4 and k+5 -> sout, sout_valid and done go to 0 and ready to 1 before the next edge; after release, 8'h81 frames correctly.
- Detector chain: drive the downstream detector's "in" from sout with 8'h25 (00100101) -> exactly three one-cycle detector out pulses.
